// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and flag bit positions shared by the sequential ALU.
// The multiplier path is built only when ALU_SEQ_MUL_EN is defined.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_MUL = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } opcode_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    localparam int unsigned FLAGS_W = 4;
    localparam int unsigned FLAG_Z  = 0;
    localparam int unsigned FLAG_C  = 1;
    localparam int unsigned FLAG_V  = 2;
    localparam int unsigned FLAG_N  = 3;

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add multiplier, one multiplier bit per clock.
// Present only when ALU_SEQ_MUL_EN is defined; the default build carries no multiplier.
`ifdef ALU_SEQ_MUL_EN
module alu_seq_mul #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    cnt;
    logic             busy;

    // Load operands on start, then add/shift once per cycle until WIDTH steps are done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= PW'(a);
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy && (cnt != CW'(WIDTH))) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end

    // Product stays valid until the next start
    assign done    = busy && (cnt == CW'(WIDTH));
    assign product = acc;

endmodule
`endif

// File: rtl/alu_seq.sv
// alu_seq: valid/ready ALU with registered result and {N,V,C,Z} flags.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier; otherwise op 101 returns err.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [FLAGS_W-1:0] flags,
    output logic               err
);

    localparam int unsigned SW = $clog2(WIDTH);

    opcode_e            op_e;
    state_e             state;
    state_e             state_n;
    logic               accept;
    logic               out_free;

    logic [WIDTH:0]     add_x;
    logic [WIDTH:0]     sub_x;
    logic [WIDTH:0]     shl_x;
    logic [WIDTH:0]     shr_x;
    logic [SW-1:0]      sh;
    logic               big_shift;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic               alu_err;

    logic               load;
    logic [WIDTH-1:0]   load_res;
    logic               load_c;
    logic               load_v;
    logic               load_err;
    logic [FLAGS_W-1:0] load_flags;

    logic               out_valid_n;
    logic [WIDTH-1:0]   result_n;
    logic [FLAGS_W-1:0] flags_n;
    logic               err_n;

    assign op_e     = opcode_e'(op);
    assign out_free = !out_valid || out_ready;
    assign in_ready = (state == ST_IDLE) && out_free;
    assign accept   = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    assign mul_start = accept && (op_e == OP_MUL);

    alu_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    // Single-cycle datapath: result, carry/borrow, overflow and error for the requested op
    always_comb begin
        add_x     = {1'b0, a} + {1'b0, b};
        sub_x     = {1'b0, a} - {1'b0, b};
        big_shift = (b >= WIDTH'(WIDTH));
        sh        = b[SW-1:0];
        shl_x     = {1'b0, a} << sh;
        shr_x     = {a, 1'b0} >> sh;
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_err   = 1'b0;
        case (op_e)
            OP_ADD: begin
                alu_res = add_x[WIDTH-1:0];
                alu_c   = add_x[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_x[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_x[WIDTH-1:0];
                alu_c   = sub_x[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_x[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_MUL: begin
`ifndef ALU_SEQ_MUL_EN
                alu_err = 1'b1;
`endif
            end
            OP_SHL: begin
                if (!big_shift) begin
                    alu_res = shl_x[WIDTH-1:0];
                    alu_c   = shl_x[WIDTH];
                end
            end
            OP_SHR: begin
                if (!big_shift) begin
                    alu_res = shr_x[WIDTH:1];
                    alu_c   = shr_x[0];
                end
            end
        endcase
    end

    // Next state and next output register values
    always_comb begin
        state_n     = state;
        out_valid_n = out_valid && !out_ready;
        result_n    = result;
        flags_n     = flags;
        err_n       = err;
        load        = 1'b0;
        load_res    = alu_res;
        load_c      = alu_c;
        load_v      = alu_v;
        load_err    = alu_err;
        load_flags  = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                    if (op_e == OP_MUL) begin
                        state_n = ST_MUL;
                    end else begin
                        load = 1'b1;
                    end
`else
                    load = 1'b1;
`endif
                end
            end
            ST_MUL: begin
`ifdef ALU_SEQ_MUL_EN
                // Final product waits here while the output slot is still occupied
                if (mul_done && out_free) begin
                    load     = 1'b1;
                    load_res = mul_product[WIDTH-1:0];
                    load_c   = |mul_product[2*WIDTH-1:WIDTH];
                    load_v   = 1'b0;
                    load_err = 1'b0;
                    state_n  = ST_IDLE;
                end
`else
                state_n = ST_IDLE;
`endif
            end
        endcase
        if (load) begin
            load_flags[FLAG_N] = load_res[WIDTH-1];
            load_flags[FLAG_V] = load_v;
            load_flags[FLAG_C] = load_c;
            load_flags[FLAG_Z] = (load_res == '0);
            out_valid_n        = 1'b1;
            result_n           = load_res;
            flags_n            = load_flags;
            err_n              = load_err;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            out_valid <= out_valid_n;
            result    <= result_n;
            flags     <= flags_n;
            err       <= err_n;
        end
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 4..64).
REQ-002 The block SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid  input  1  operation request valid.
REQ-005 The block SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-006 The block SHALL have port a  input  WIDTH  operand A.
REQ-007 The block SHALL have port b  input  WIDTH  operand B, or shift amount for shift ops.
REQ-008 The block SHALL have port op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 SHL, 111 SHR.
REQ-009 The block SHALL have port out_valid  output  1  result valid.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 The block SHALL have port result  output  WIDTH  registered result.
REQ-012 The block SHALL have port flags  output  4  registered {N,V,C,Z}, bit 3 = N, bit 0 = Z.
REQ-013 The block SHALL have port err  output  1  result produced by an unsupported opcode.

Function
REQ-014 Accept SHALL occur on a rising clk edge where in_valid && in_ready; a, b and op are sampled only at accept.
REQ-015 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready), combinationally; back-to-back single-cycle ops SHALL sustain one result per cycle.
REQ-016 FSM states SHALL be IDLE and MUL; IDLE->MUL on accept of op 101 (macro on); MUL->IDLE when product is written to output; all other ops stay in IDLE.
REQ-017 Ops 000-100, 110, 111 SHALL have latency 1: accepted at edge N, out_valid high after edge N+1 with result.
REQ-018 MUL SHALL be iterative shift-add, one bit per cycle; result SHALL appear WIDTH+1 edges after accept, unless the output is still occupied.
REQ-019 If the final MUL step occurs while out_valid && !out_ready, the block SHALL hold in MUL with the product preserved until the output frees.
REQ-020 out_valid, result, flags and err SHALL remain stable while out_valid && !out_ready; out_valid SHALL clear on out_ready unless a new result is loaded the same edge.
REQ-021 ADD/SUB/logic results SHALL be modulo 2^WIDTH; MUL result SHALL be the low WIDTH bits of the unsigned product.
REQ-022 SHL/SHR SHALL be logical shifts by unsigned b; for b >= WIDTH, result = 0 and C = 0.
REQ-023 Z SHALL be (result==0); N SHALL be result[WIDTH-1].
REQ-024 C SHALL be: ADD carry-out; SUB borrow (a<b unsigned); SHL/SHR last bit shifted out (0 when b==0); MUL 1 if product high half is nonzero; logic ops 0.
REQ-025 V SHALL be signed overflow for ADD/SUB and 0 for all other ops.
REQ-026 err SHALL be 0 for every supported opcode.

Reset
REQ-027 While rst_n is low, state SHALL be IDLE; out_valid, result, flags, err SHALL be 0; in_ready SHALL be 1.
REQ-028 Reset asserted mid-MUL SHALL abort the operation with no result emitted; the first accept after release SHALL proceed normally.

Configuration
REQ-029 Macro ALU_SEQ_MUL_EN defined: MUL SHALL be implemented per REQ-018/019.
REQ-030 Macro ALU_SEQ_MUL_EN undefined: op 101 SHALL complete with latency 1, result 0, flags 4'b0001, err 1; no multiplier logic SHALL be instantiated and state MUL SHALL be unreachable.

Structure
REQ-031 Package alu_seq_pkg SHALL hold the opcode enum, FSM state enum and flag bit-index constants (FLAG_Z=0, FLAG_C=1, FLAG_V=2, FLAG_N=3).
REQ-032 The iterative multiplier SHALL be a sub-module alu_seq_mul (start, a, b -> done, product[2*WIDTH]), instantiated only under ALU_SEQ_MUL_EN.

Verification (WIDTH=8)
REQ-033 ADD a=0xFF, b=0x01, out_ready=1 -> next cycle result 0x00, flags N0 V0 C1 Z1, err 0.
REQ-034 SUB a=0x80, b=0x01 -> result 0x7F, V1 C0 N0 Z0; back-to-back XOR 0xF0^0x0F issued next cycle -> result 0xFF, N1, one result per cycle.
REQ-035 MUL a=0x10, b=0x11 (macro on) -> result 0x10, C1, out_valid exactly 9 edges after accept, in_ready 0 throughout.
REQ-036 SHL a=0x81, b=1 -> result 0x02, C1; SHR a=0x81, b=8 -> result 0x00, C0, Z1.
REQ-037 Hold out_ready=0 for 5 cycles after ADD -> result/flags stable, in_ready 0; assert rst_n low during MUL cycle 4 -> out_valid 0, no late result after release.
REQ-038 Macro off, op 101 -> result 0x00, flags 4'b0001, err 1, latency 1.
